// File: rtl/multi_pulse_sync_rx.sv
// multi_pulse_sync_rx: per-channel toggle synchroniser, edge detect, pending counters and round-robin event drain.
// Define MPS_OVF_FLAG_EN to build the sticky per-channel overflow flags; otherwise ovf is tied to 0.
module multi_pulse_sync_rx #(
   parameter int CH = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PEND_W = 3,
   localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic            clk_dst,
   input  logic            rst,
   input  logic [CH-1:0]   tgl_in,
   output logic [CH-1:0]   ev_pulse,
   output logic            ev_valid,
   input  logic            ev_ready,
   output logic [CH_W-1:0] ev_ch,
   output logic [CH-1:0]   ovf
);
   logic [CH-1:0]     sync_q [SYNC_STAGES];
   logic [CH-1:0]     sync_d [SYNC_STAGES];
   logic [CH-1:0]     last_q, last_d, pulse_q, pulse_d, dec;
   logic [PEND_W-1:0] pend_q [CH];
   logic [PEND_W-1:0] pend_d [CH];
   logic              valid_q, valid_d, any, load;
   logic [CH_W-1:0]   ch_q, ch_d, rr_q, rr_d, grant;
   int                idx;
   always_comb begin
      sync_d[0] = tgl_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
      last_d  = sync_q[SYNC_STAGES-1];
      pulse_d = sync_q[SYNC_STAGES-1] ^ last_q;
      // scan downward so the lowest offset from rr_q wins
      grant = '0;
      any   = 1'b0;
      idx   = 0;
      for (int i = CH - 1; i >= 0; i--) begin
         idx = (int'(rr_q) + i) % CH;
         if (pend_q[idx] != '0) begin
            grant = CH_W'(idx);
            any   = 1'b1;
         end
      end
      load    = (!valid_q || ev_ready) && any;
      valid_d = (!valid_q || ev_ready) ? any : valid_q;
      ch_d    = load ? grant : ch_q;
      rr_d    = load ? CH_W'((int'(grant) + 1) % CH) : rr_q;
      for (int c = 0; c < CH; c++) begin
         dec[c]    = load && (grant == CH_W'(c));
         pend_d[c] = (pulse_q[c] && !dec[c]) ? ((&pend_q[c]) ? pend_q[c] : pend_q[c] + PEND_W'(1)) :
                     (!pulse_q[c] && dec[c]) ? pend_q[c] - PEND_W'(1) : pend_q[c];
      end
   end
   always_ff @(posedge clk_dst) begin
      if (rst) begin
         sync_q  <= '{default: '0};
         last_q  <= '0;
         pulse_q <= '0;
         pend_q  <= '{default: '0};
         valid_q <= 1'b0;
         ch_q    <= '0;
         rr_q    <= '0;
      end else begin
         sync_q  <= sync_d;
         last_q  <= last_d;
         pulse_q <= pulse_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         ch_q    <= ch_d;
         rr_q    <= rr_d;
      end
   end
   assign ev_pulse = pulse_q;
   assign ev_valid = valid_q;
   assign ev_ch    = ch_q;
`ifdef MPS_OVF_FLAG_EN
   logic [CH-1:0] ovf_q, ovf_d;
   always_comb begin
      ovf_d = ovf_q;
      for (int c = 0; c < CH; c++) ovf_d[c] = ovf_q[c] | (pulse_q[c] && !dec[c] && (&pend_q[c]));
   end
   always_ff @(posedge clk_dst) begin
      if (rst) ovf_q <= '0;
      else     ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`else
   assign ovf = '0;
`endif
endmodule

// File: tb/tb_multi_pulse_sync_rx.sv
// tb_multi_pulse_sync_rx: directed timing scenarios plus a randomized conservation scoreboard.
module tb_multi_pulse_sync_rx;
   localparam int CH = 4;
`ifdef MPS_OVF_FLAG_EN
   localparam logic [CH-1:0] OVF_EXP = 4'b0100;
`else
   localparam logic [CH-1:0] OVF_EXP = 4'b0000;
`endif
   logic          clk_dst = 1'b0;
   logic          rst = 1'b1;
   logic          ev_ready = 1'b0;
   logic [CH-1:0] tgl_in = '0;
   logic [CH-1:0] ev_pulse, ovf;
   logic          ev_valid;
   logic [1:0]    ev_ch;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int got_ch[$];
   int got_cyc[$];

   multi_pulse_sync_rx #(.CH(CH), .SYNC_STAGES(2), .PEND_W(3)) dut (
      .clk_dst(clk_dst), .rst(rst), .tgl_in(tgl_in), .ev_pulse(ev_pulse),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ovf(ovf)
   );

   always #5 clk_dst = ~clk_dst;

   task automatic step();
      @(posedge clk_dst);
      #1;
      cyc++;
   endtask

   task automatic collect(input int n);
      got_ch.delete();
      got_cyc.delete();
      for (int i = 0; i < n; i++) begin
         if (ev_valid && ev_ready) begin
            got_ch.push_back(int'(ev_ch));
            got_cyc.push_back(cyc);
         end
         step();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tgl_in = '0;
      ev_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ev_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tgl_in = tgl_in ^ 4'b1011;
         step();
         checks++;
         if ({ev_pulse, ev_valid, ev_ch, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_hold pulse=%b valid=%b ch=%0d ovf=%b exp all 0", ev_pulse, ev_valid, ev_ch, ovf);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (ev_valid !== 1'b0 || ev_pulse !== '0) begin
            errors++;
            $display("FAIL reset_release valid=%b pulse=%b exp 0/0", ev_valid, ev_pulse);
         end
      end
   endtask

   task automatic test_single();
      logic [CH-1:0] exp_p [4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000};
      do_reset();
      ev_ready = 1'b1;
      tgl_in[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (ev_pulse !== exp_p[k] || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse edge n+%0d pulse=%b valid=%b exp %b/0", k, ev_pulse, ev_valid, exp_p[k]);
         end
      end
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_ch !== 2'd1) begin
         errors++;
         $display("FAIL single_valid valid=%b ch=%0d exp 1/1", ev_valid, ev_ch);
      end
      step();
      checks++;
      if (ev_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drop valid=%b exp 0", ev_valid);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         tgl_in[0] = ~tgl_in[0];
         for (int j = 0; j < 4; j++) begin
            step();
            if (k > 0) begin
               checks++;
               if (ev_valid !== 1'b1 || ev_ch !== 2'd0) begin
                  errors++;
                  $display("FAIL bp_hold valid=%b ch=%0d exp 1/0", ev_valid, ev_ch);
               end
            end
         end
      end
      repeat (4) step();
      ev_ready = 1'b1;
      collect(8);
      checks++;
      if (got_ch.size() !== 3) begin
         errors++;
         $display("FAIL bp_count got=%0d exp 3", got_ch.size());
      end
      for (int i = 0; i < got_ch.size(); i++) begin
         checks++;
         if (got_ch[i] !== 0 || got_cyc[i] !== got_cyc[0] + i) begin
            errors++;
            $display("FAIL bp_seq idx %0d ch=%0d cyc=%0d exp ch 0 cyc %0d", i, got_ch[i], got_cyc[i], got_cyc[0] + i);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_a[4] = '{0, 1, 2, 3};
      int exp_b[2] = '{0, 2};
      do_reset();
      ev_ready = 1'b1;
      tgl_in = tgl_in ^ 4'b1111;
      collect(10);
      checks++;
      if (got_ch.size() !== 4) begin
         errors++;
         $display("FAIL rr_all_count got=%0d exp 4", got_ch.size());
      end
      for (int i = 0; i < got_ch.size() && i < 4; i++) begin
         checks++;
         if (got_ch[i] !== exp_a[i] || got_cyc[i] !== got_cyc[0] + i) begin
            errors++;
            $display("FAIL rr_all idx %0d ch=%0d exp %0d", i, got_ch[i], exp_a[i]);
         end
      end
      tgl_in = tgl_in ^ 4'b0101;
      collect(10);
      checks++;
      if (got_ch.size() !== 2) begin
         errors++;
         $display("FAIL rr_pair_count got=%0d exp 2", got_ch.size());
      end
      for (int i = 0; i < got_ch.size() && i < 2; i++) begin
         checks++;
         if (got_ch[i] !== exp_b[i] || got_cyc[i] !== got_cyc[0] + i) begin
            errors++;
            $display("FAIL rr_pair idx %0d ch=%0d exp %0d", i, got_ch[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (9) begin
         tgl_in[2] = ~tgl_in[2];
         repeat (3) step();
      end
      repeat (6) step();
      checks++;
      if (ovf !== OVF_EXP || ev_valid !== 1'b1 || ev_ch !== 2'd2) begin
         errors++;
         $display("FAIL sat_flag ovf=%b valid=%b ch=%0d exp %b/1/2", ovf, ev_valid, ev_ch, OVF_EXP);
      end
      ev_ready = 1'b1;
      collect(16);
      checks++;
      if (got_ch.size() !== 8) begin
         errors++;
         $display("FAIL sat_count got=%0d exp 8", got_ch.size());
      end
      for (int i = 0; i < got_ch.size(); i++) begin
         checks++;
         if (got_ch[i] !== 2 || got_cyc[i] !== got_cyc[0] + i) begin
            errors++;
            $display("FAIL sat_seq idx %0d ch=%0d exp 2", i, got_ch[i]);
         end
      end
      checks++;
      if (ovf !== OVF_EXP) begin
         errors++;
         $display("FAIL sat_sticky ovf=%b exp %b", ovf, OVF_EXP);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      repeat (5) begin
         tgl_in[3] = ~tgl_in[3];
         repeat (3) step();
      end
      repeat (6) step();
      checks++;
      if (ev_valid !== 1'b1 || ev_ch !== 2'd3) begin
         errors++;
         $display("FAIL mid_pre valid=%b ch=%0d exp 1/3", ev_valid, ev_ch);
      end
      rst = 1'b1;
      tgl_in = '0;
      step();
      rst = 1'b0;
      checks++;
      if (ev_valid !== 1'b0 || ovf !== '0 || ev_pulse !== '0) begin
         errors++;
         $display("FAIL mid_reset valid=%b ovf=%b pulse=%b exp 0", ev_valid, ovf, ev_pulse);
      end
      ev_ready = 1'b1;
      collect(12);
      checks++;
      if (got_ch.size() !== 0) begin
         errors++;
         $display("FAIL mid_after got=%0d events exp 0", got_ch.size());
      end
   endtask

   task automatic test_random();
      int tog[CH], pul[CH], hs[CH], last_t[CH];
      logic pv, pr;
      logic [1:0] pc;
      do_reset();
      for (int c = 0; c < CH; c++) begin
         tog[c] = 0; pul[c] = 0; hs[c] = 0; last_t[c] = -10;
      end
      pv = 1'b0; pr = 1'b0; pc = '0;
      for (int t = 0; t < 540; t++) begin
         if (pv && !pr) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_ch !== pc) begin
               errors++;
               $display("FAIL rnd_stable t=%0d valid=%b ch=%0d exp 1/%0d", t, ev_valid, ev_ch, pc);
            end
         end
         for (int c = 0; c < CH; c++) if (ev_pulse[c]) pul[c]++;
         ev_ready = (t >= 500) ? 1'b1 : ($urandom_range(0, 9) < 7);
         if (ev_valid && ev_ready) begin
            checks++;
            if (hs[int'(ev_ch)] >= pul[int'(ev_ch)]) begin
               errors++;
               $display("FAIL rnd_spurious t=%0d ch=%0d handshakes=%0d pulses=%0d", t, ev_ch, hs[int'(ev_ch)], pul[int'(ev_ch)]);
            end
            hs[int'(ev_ch)]++;
         end
         for (int c = 0; c < CH; c++) begin
            if (t < 500 && t - last_t[c] >= 3 && tog[c] - hs[c] < 5 && $urandom_range(0, 3) == 0) begin
               tgl_in[c] = ~tgl_in[c];
               tog[c]++;
               last_t[c] = t;
            end
         end
         pv = ev_valid;
         pr = ev_ready;
         pc = ev_ch;
         step();
      end
      for (int c = 0; c < CH; c++) begin
         checks++;
         if (pul[c] !== tog[c] || hs[c] !== tog[c]) begin
            errors++;
            $display("FAIL rnd_total ch %0d pulses=%0d events=%0d exp %0d", c, pul[c], hs[c], tog[c]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_round_robin();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multi_pulse_sync_rx.md
Name: multi_pulse_sync_rx

Overview:
- Destination-domain receiver for N independent pulse-crossing channels.
- Each source domain converts its pulses to a toggle level, which arrives asynchronously on tgl_in.
- The block synchronises each toggle through SYNC_STAGES flops, edge-detects it into a one-cycle pulse, and counts pending events per channel.
- Pending events are drained one at a time through a valid/ready event port, with a round-robin arbiter across channels.

Parameters:
- CH, 4, number of channels (>=1).
- SYNC_STAGES, 2, synchroniser depth per channel (>=2).
- PEND_W, 3, width of each per-channel pending counter; max pending = 2^PEND_W-1.
- CH_W, (CH>1 ? $clog2(CH) : 1), derived width of the channel index; not overridable.

Ports:
- clk_dst  input  1  destination clock; the only clock in the block.
- rst  input  1  reset; synchronous, active-high.
- tgl_in  input  CH  asynchronous toggle level per channel; each source-side toggle flop resets to 0.
- ev_pulse  output  CH  registered one-cycle pulse per detected toggle edge.
- ev_valid  output  1  an event is presented on ev_ch.
- ev_ready  input  1  consumer accepts the event; handshake completes when ev_valid && ev_ready at a clk_dst edge.
- ev_ch  output  CH_W  channel index of the presented event.
- ovf  output  CH  sticky per-channel overflow flag; see Optional Feature.

Behaviour:
- Reset: synchronous to clk_dst, active-high. All sync flops, edge registers and pending counters clear to 0. Outputs reset to ev_pulse=0, ev_valid=0, ev_ch=0, ovf=0. The round-robin pointer resets to 0. A reset asserted mid-operation discards all pending and presented events, and no event is emitted for them afterwards.
- Sync and edge detect: edge n is the first clk_dst edge that samples a new tgl_in level. ev_pulse[c] is 1 for exactly one cycle, following edge n+SYNC_STAGES. Both 0->1 and 1->0 transitions count as one event each.
- Source constraint: each tgl_in level must be held for at least 2 clk_dst periods. Faster toggling is undefined and is not detected.
- Pending counter pend[c]:
  - Increments on the edge after ev_pulse[c].
  - Decrements when channel c is loaded into the output register.
  - Simultaneous increment and decrement on the same channel leaves the count unchanged.
  - Saturates at 2^PEND_W-1. An increment at saturation (without a simultaneous decrement) is dropped.
- Output register load condition: (!ev_valid || ev_ready) and at least one pend[c]>0.
- On load:
  - The arbiter grants the first channel with pend>0, searching upward from rr_ptr with wrap-around mod CH.
  - ev_ch <= grant; ev_valid <= 1; pend[grant] decrements; rr_ptr <= (grant+1) mod CH.
- If (!ev_valid || ev_ready) and no channel is pending, ev_valid <= 0 and ev_ch holds its value.
- While ev_valid && !ev_ready, ev_ch and ev_valid are held stable.
- Throughput is one event per cycle while ev_ready=1. A presented event is never dropped.
- Latency for an idle block: ev_valid rises after edge n+SYNC_STAGES+2.
- For CH=1, the arbiter always grants channel 0 and ev_ch stays 0.

Optional Feature:
- Macro: MPS_OVF_FLAG_EN.
- Defined: ovf[c] is set on a dropped increment (saturation) and is sticky until rst.
- Undefined: the ovf port is tied to 0, no flag logic is built, and saturation still drops silently.

Test Plan:
- Reset: hold rst=1 for 2 cycles while tgl_in toggles -> ev_pulse=0, ev_valid=0, ev_ch=0, ovf=0 throughout, and no events after release (tgl_in kept static at release).
- Single event, SYNC_STAGES=2: tgl_in[1] 0->1 first sampled at edge n, ev_ready=1 -> ev_pulse[1]=1 for one cycle after edge n+2; ev_valid=1 with ev_ch=1 for one cycle after edge n+4; then ev_valid=0.
- Backpressure: ev_ready=0, three toggles on ch0 spaced 4 cycles apart -> ev_valid stays 1 with ev_ch=0 stable. Raise ev_ready -> exactly 3 handshakes on consecutive cycles, all ev_ch=0, then ev_valid=0.
- Round-robin: all 4 channels toggle on the same edge, ev_ready=1 -> ev_ch sequence 0,1,2,3 on consecutive cycles. Repeat with ch0 and ch2 only -> sequence 0,2, because the pointer wrapped to 0 after 3.
- Saturation, PEND_W=3: ev_ready=0, 9 toggles on ch2 spaced 3 cycles apart -> the 9th is dropped; ovf[2]=1 with MPS_OVF_FLAG_EN, ovf=0 without. Release ev_ready -> exactly 8 events with ev_ch=2.
- Reset mid-operation: 5 events pending on ch3 with ev_ready=0; pulse rst for 1 cycle -> ev_valid=0 and ovf=0 on the next cycle, and no ch3 event after release.
